// File: rtl/snake_game_ctrl.sv
// Snake game controller: tick-driven body movement, collision handling and LFSR food placement.
// Define SNAKE_WRAP_EN to let the head wrap across grid edges instead of ending the game.
module snake_game_ctrl #(
  parameter int TICK_DIV = 10000000,
  parameter int MAX_LEN  = 8,
  parameter int GRID     = 12
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       start,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  input  logic [3:0] seg_idx,
  output logic [3:0] seg_x,
  output logic [3:0] seg_y,
  output logic [3:0] food_x,
  output logic [3:0] food_y,
  output logic [4:0] snake_len,
  output logic [7:0] score,
  output logic       running,
  output logic       game_over,
  output logic       step_pulse
);

  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CELLS = GRID * GRID;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_FOOD, S_OVER} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t        r_state, w_nextState;
  dir_t          r_dir, w_reqDir;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_lfsr;
  logic [3:0]    r_segX [MAX_LEN];
  logic [3:0]    r_segY [MAX_LEN];
  logic [4:0]    r_len;
  logic [7:0]    r_score;
  logic [3:0]    r_foodX, r_foodY;
  logic [3:0]    r_scanX, r_scanY;
  logic          r_stepPulse;

  logic       w_reqValid, w_opposite, w_tickWrap, w_reinit;
  logic [4:0] w_nx5, w_ny5, w_limit;
  logic [3:0] w_nextX, w_nextY;
  logic       w_out, w_eat, w_hit, w_scanHit, w_commitMove, w_grow;
  logic [8:0] w_seedCell;
  logic [3:0] w_seedX, w_seedY;

  assign w_tickWrap   = (r_tick == TW'(TICK_DIV - 1));
  assign w_reinit     = (r_state == S_OVER) && start;
  assign w_eat        = (w_nextX == r_foodX) && (w_nextY == r_foodY);
  assign w_commitMove = (r_state == S_MOVE) && !w_out && !w_hit;
  assign w_grow       = w_commitMove && w_eat;

  assign w_seedCell = {1'b0, r_lfsr} % 9'(CELLS);
  assign w_seedX    = 4'(w_seedCell % 9'(GRID));
  assign w_seedY    = 4'(w_seedCell / 9'(GRID));

  always_comb begin
    w_reqValid = 1'b1;
    w_reqDir   = r_dir;
    if (move_up)         w_reqDir = D_UP;
    else if (move_down)  w_reqDir = D_DOWN;
    else if (move_left)  w_reqDir = D_LEFT;
    else if (move_right) w_reqDir = D_RIGHT;
    else                 w_reqValid = 1'b0;
  end

  // Opposite directions share bit 1 and differ in bit 0 (UP/DOWN, LEFT/RIGHT).
  assign w_opposite = (w_reqDir[1] == r_dir[1]) && (w_reqDir[0] != r_dir[0]);

  always_comb begin
    w_nx5 = {1'b0, r_segX[0]};
    w_ny5 = {1'b0, r_segY[0]};
    case (r_dir)
      D_UP:    w_ny5 = w_ny5 - 5'd1;
      D_DOWN:  w_ny5 = w_ny5 + 5'd1;
      D_LEFT:  w_nx5 = w_nx5 - 5'd1;
      default: w_nx5 = w_nx5 + 5'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    w_out   = 1'b0;
    w_nextX = (w_nx5 == 5'(GRID)) ? 4'd0 : ((w_nx5 == 5'h1F) ? 4'(GRID - 1) : w_nx5[3:0]);
    w_nextY = (w_ny5 == 5'(GRID)) ? 4'd0 : ((w_ny5 == 5'h1F) ? 4'(GRID - 1) : w_ny5[3:0]);
`else
    w_out   = (w_nx5 >= 5'(GRID)) || (w_ny5 >= 5'(GRID));
    w_nextX = w_nx5[3:0];
    w_nextY = w_ny5[3:0];
`endif
  end

  // The tail vacates its cell on a plain move, so it only blocks the head when eating.
  always_comb begin
    w_hit   = 1'b0;
    w_limit = w_eat ? r_len : (r_len - 5'd1);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < w_limit) && (r_segX[i] == w_nextX) && (r_segY[i] == w_nextY))
        w_hit = 1'b1;
    end
  end

  always_comb begin
    w_scanHit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < r_len) && (r_segX[i] == r_scanX) && (r_segY[i] == r_scanY))
        w_scanHit = 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (w_tickWrap) w_nextState = S_MOVE;
      S_MOVE: begin
        if (w_out || w_hit) w_nextState = S_OVER;
        else if (w_eat)     w_nextState = S_FOOD;
        else                w_nextState = S_RUN;
      end
      S_FOOD:  if (!w_scanHit) w_nextState = S_RUN;
      S_OVER:  if (start) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)               r_tick <= '0;
    else if (r_state != S_RUN) r_tick <= '0;
    else if (w_tickWrap)       r_tick <= '0;
    else                       r_tick <= r_tick + TW'(1);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)
      r_dir <= D_RIGHT;
    else if (w_reinit)
      r_dir <= D_RIGHT;
    else if ((r_state == S_RUN) && w_reqValid && !w_opposite)
      r_dir <= w_reqDir;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_lfsr <= 8'h01;
    else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= (i < 4) ? 4'(6 - i) : 4'd0;
        r_segY[i] <= (i < 4) ? 4'd6 : 4'd0;
      end
      r_len   <= 5'd4;
      r_score <= 8'd0;
      r_foodX <= 4'd2;
      r_foodY <= 4'd2;
    end else if (w_reinit) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= (i < 4) ? 4'(6 - i) : 4'd0;
        r_segY[i] <= (i < 4) ? 4'd6 : 4'd0;
      end
      r_len   <= 5'd4;
      r_score <= 8'd0;
      r_foodX <= 4'd2;
      r_foodY <= 4'd2;
    end else begin
      if (w_commitMove) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          r_segX[i] <= r_segX[i-1];
          r_segY[i] <= r_segY[i-1];
        end
        r_segX[0] <= w_nextX;
        r_segY[0] <= w_nextY;
      end
      if (w_grow) begin
        if (r_len < 5'(MAX_LEN)) r_len <= r_len + 5'd1;
        if (r_score != 8'hFF)    r_score <= r_score + 8'd1;
      end
      if ((r_state == S_FOOD) && !w_scanHit) begin
        r_foodX <= r_scanX;
        r_foodY <= r_scanY;
      end
    end
  end

  // Scan walks cells in row-major order, wrapping from the last cell back to cell 0.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_scanX <= 4'd0;
      r_scanY <= 4'd0;
    end else if (w_grow) begin
      r_scanX <= w_seedX;
      r_scanY <= w_seedY;
    end else if (r_state == S_FOOD) begin
      if (r_scanX == 4'(GRID - 1)) begin
        r_scanX <= 4'd0;
        r_scanY <= (r_scanY == 4'(GRID - 1)) ? 4'd0 : r_scanY + 4'd1;
      end else begin
        r_scanX <= r_scanX + 4'd1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_stepPulse <= 1'b0;
    else         r_stepPulse <= w_commitMove;
  end

  always_comb begin
    seg_x = 4'd0;
    seg_y = 4'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((seg_idx == 4'(i)) && (5'(i) < r_len)) begin
        seg_x = r_segX[i];
        seg_y = r_segY[i];
      end
    end
  end

  assign food_x     = r_foodX;
  assign food_y     = r_foodY;
  assign snake_len  = r_len;
  assign score      = r_score;
  assign step_pulse = r_stepPulse;
  assign running    = (r_state == S_RUN) || (r_state == S_MOVE) || (r_state == S_FOOD);
  assign game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=16: stepping, steering, eating, collisions, reset.
module tb_snake_game_ctrl;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       start = 1'b0;
  logic       move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic [3:0] seg_idx = 4'd0;
  logic [3:0] seg_x, seg_y, food_x, food_y;
  logic [4:0] snake_len;
  logic [7:0] score;
  logic       running, game_over, step_pulse;

  int numChecks = 0;
  int numPassed = 0;
  int lastWait  = 0;

  snake_game_ctrl #(.TICK_DIV(16), .MAX_LEN(8), .GRID(12)) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .start(start),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .food_x(food_x), .food_y(food_y),
    .snake_len(snake_len), .score(score), .running(running), .game_over(game_over),
    .step_pulse(step_pulse)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic checkOutput(input string tag, input int got, input int exp);
    numChecks++;
    if (got == exp) numPassed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic checkSeg(input string tag, input int idx, input int ex, input int ey);
    seg_idx = 4'(idx);
    #1;
    checkOutput({tag, "_x"}, int'(seg_x), ex);
    checkOutput({tag, "_y"}, int'(seg_y), ey);
  endtask

  task automatic setButtons(input logic u, input logic d, input logic l, input logic r);
    move_up = u; move_down = d; move_left = l; move_right = r;
  endtask

  task automatic applyStimulus(input logic doReset);
    if (doReset) begin
      iRST_n = 1'b0;
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      @(negedge iVGA_CLK);
    end else begin
      start = 1'b1;
      @(negedge iVGA_CLK);
      start = 1'b0;
    end
  endtask

  task automatic waitStep();
    int n = 0;
    do begin
      @(negedge iVGA_CLK);
      n++;
    end while (!step_pulse && n < 300);
    lastWait = n;
    if (!step_pulse) checkOutput("step_timeout", 0, 1);
  endtask

  task automatic waitOver();
    int n = 0;
    do begin
      @(negedge iVGA_CLK);
      n++;
    end while (!game_over && n < 300);
    if (!game_over) checkOutput("over_timeout", 0, 1);
  endtask

  task automatic doSteps(input int n, input logic u, input logic d, input logic l, input logic r);
    setButtons(u, d, l, r);
    repeat (n) waitStep();
    setButtons(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkSeg({tag, "_s0"}, 0, 6, 6);
    checkSeg({tag, "_s3"}, 3, 3, 6);
    checkOutput({tag, "_len"}, int'(snake_len), 4);
    checkOutput({tag, "_score"}, int'(score), 0);
    checkOutput({tag, "_food_x"}, int'(food_x), 2);
    checkOutput({tag, "_food_y"}, int'(food_y), 2);
    checkOutput({tag, "_running"}, int'(running), 0);
    checkOutput({tag, "_over"}, int'(game_over), 0);
    checkOutput({tag, "_pulse"}, int'(step_pulse), 0);
  endtask

  initial begin
    int  ey;
    bit  useDown;
    bit  foodOk;
    int  bodyX[5] = '{2, 3, 4, 5, 6};

    // Reset state
    applyStimulus(1'b1);
    checkResetState("rst");
    checkSeg("rst_s1", 1, 5, 6);
    checkSeg("rst_s2", 2, 4, 6);

    // First step: 16 RUN cycles plus the MOVE cycle
    applyStimulus(1'b0);
    waitStep();
    checkOutput("first_step_cycles", lastWait, 17);
    checkSeg("step1_head", 0, 7, 6);
    checkSeg("step1_tail", 3, 4, 6);
    checkOutput("step1_score", int'(score), 0);
    checkOutput("step1_running", int'(running), 1);
    @(negedge iVGA_CLK);
    checkOutput("pulse_once", int'(step_pulse), 0);

    // Run right to the edge of the grid
    doSteps(4, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSeg("edge_head", 0, 11, 6);
`ifdef SNAKE_WRAP_EN
    waitStep();
    checkSeg("wrap_head", 0, 0, 6);
    checkOutput("wrap_running", int'(running), 1);
    checkOutput("wrap_over", int'(game_over), 0);
    checkSeg("wrap_len_bound", 4, 0, 0);
    applyStimulus(1'b1);
`else
    waitOver();
    checkOutput("wall_over", int'(game_over), 1);
    checkOutput("wall_running", int'(running), 0);
    checkSeg("wall_head", 0, 11, 6);
    checkSeg("wall_tail", 3, 8, 6);
    checkSeg("wall_len_bound", 4, 0, 0);
    applyStimulus(1'b0);
    checkResetState("restart");
`endif

    // Opposite request ignored, then steer up
    applyStimulus(1'b0);
    setButtons(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge iVGA_CLK);
    setButtons(1'b0, 1'b0, 1'b0, 1'b0);
    waitStep();
    checkSeg("opp_ignored_head", 0, 7, 6);
    doSteps(1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSeg("up_head", 0, 7, 5);
    checkSeg("up_neck", 1, 7, 6);
    doSteps(3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSeg("up3_head", 0, 7, 2);

    // Left beats right; the fifth step eats the food at (2,2)
    doSteps(5, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("eat_len", int'(snake_len), 5);
    checkOutput("eat_score", int'(score), 1);
    checkSeg("eat_head", 0, 2, 2);
    checkSeg("eat_tail", 4, 6, 2);
    repeat (8) @(negedge iVGA_CLK);
    checkOutput("food_running", int'(running), 1);
    checkOutput("food_x_range", int'(food_x < 4'd12), 1);
    checkOutput("food_y_range", int'(food_y < 4'd12), 1);
    foodOk = 1'b1;
    for (int i = 0; i < 5; i++)
      if (int'(food_x) == bodyX[i] && food_y == 4'd2) foodOk = 1'b0;
    checkOutput("food_free", int'(foodOk), 1);

    // Loop back into the body; detour around the new food if it sits on the upper path
    useDown = (food_y == 4'd1) && (food_x == 4'd2 || food_x == 4'd3);
    ey = useDown ? 3 : 1;
    doSteps(1, !useDown, useDown, 1'b0, 1'b0);
    checkSeg("loop1_head", 0, 2, ey);
    doSteps(1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSeg("loop2_head", 0, 3, ey);
    checkOutput("loop2_len", int'(snake_len), 5);
    setButtons(useDown, !useDown, 1'b0, 1'b0);
    waitOver();
    setButtons(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("self_over", int'(game_over), 1);
    checkOutput("self_running", int'(running), 0);
    checkSeg("self_head", 0, 3, ey);
    checkSeg("self_neck", 1, 2, ey);
    checkSeg("self_s3", 3, 3, 2);
    checkOutput("self_len", int'(snake_len), 5);
    checkOutput("self_score", int'(score), 1);

    applyStimulus(1'b0);
    checkResetState("restart2");

    // Eat again and reset while the food scan is in progress
    applyStimulus(1'b0);
    doSteps(1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSeg("rerun_head", 0, 7, 6);
    doSteps(4, 1'b1, 1'b0, 1'b0, 1'b0);
    doSteps(5, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("food_phase_running", int'(running), 1);
    checkOutput("food_phase_len", int'(snake_len), 5);
    applyStimulus(1'b1);
    checkResetState("midfood");
    checkSeg("midfood_s4", 4, 0, 0);

    $display("[TB] %0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, meaning iVGA_CLK cycles per game step.
REQ-002 SHALL have parameter MAX_LEN, default 8, meaning maximum snake segment count (4..16).
REQ-003 SHALL have parameter GRID, default 12, meaning cells per side of the square playfield.
REQ-004 iVGA_CLK  input  1  clock; all state updates on its rising edge.
REQ-005 iRST_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  level; starts a game from IDLE or OVER.
REQ-007 move_up, move_down, move_left, move_right  input  1 each  level direction requests.
REQ-008 seg_idx  input  4  segment read index; 0 is the head.
REQ-009 seg_x, seg_y  output  4 each  combinational cell coordinates of segment seg_idx; 0 when seg_idx >= snake_len.
REQ-010 food_x, food_y  output  4 each  food cell coordinates.
REQ-011 snake_len  output  5  current segment count.
REQ-012 score  output  8  food items eaten.
REQ-013 running, game_over  output  1 each  state flags.
REQ-014 step_pulse  output  1  one-cycle strobe when body registers have just updated.

Function
REQ-015 States SHALL be IDLE, RUN, MOVE, FOOD, OVER, one-hot or encoded, with one state transition per cycle at most.
REQ-016 IDLE -> RUN when start=1; OVER -> IDLE when start=1, re-initialising body, food, score, length and direction.
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and move RUN -> MOVE on the wrap cycle.
REQ-018 Direction register SHALL update every cycle in RUN from buttons with priority up > down > left > right; a request exactly opposite the current direction SHALL be ignored; no button keeps the direction.
REQ-019 MOVE SHALL compute next head = head +/- 1 on one axis (up = y-1, right = x+1) and resolve collision in the same cycle.
REQ-020 Self-collision: next head equal to any segment 0..snake_len-2, or 0..snake_len-1 when eating, SHALL go to OVER without updating the body.
REQ-021 Eating (next head == food) SHALL shift body, insert new head, grow snake_len by 1 if below MAX_LEN, increment score saturating at 255, go to FOOD.
REQ-022 Non-eating move SHALL shift body (segment i <= segment i-1) and go to RUN; step_pulse asserts in the cycle after the shift.
REQ-023 FOOD SHALL scan cell indices from a free-running 8-bit LFSR seed modulo GRID*GRID, one cell per cycle, wrapping GRID*GRID-1 -> 0, and place food on the first cell not occupied by any segment, then return to RUN.
REQ-024 Tick counter SHALL hold at 0 during MOVE and FOOD.
REQ-025 running = 1 in RUN, MOVE, FOOD; game_over = 1 only in OVER.

Reset
REQ-026 Asynchronous reset SHALL force IDLE, segments 0..3 = (6,6),(5,6),(4,6),(3,6), others (0,0), snake_len=4, direction right, food (2,2), score 0, tick 0, LFSR 8'h01, all flag outputs 0.
REQ-027 Reset asserted mid-MOVE or mid-FOOD SHALL abandon the operation with no partial body or food update visible after release.

Configuration
REQ-028 Macro SNAKE_WRAP_EN defined: head leaving the grid SHALL wrap to the opposite edge (x = GRID-1 + 1 -> 0, 0 - 1 -> GRID-1).
REQ-029 Macro SNAKE_WRAP_EN undefined: next head outside 0..GRID-1 SHALL go to OVER with body unchanged.

Verification (TICK_DIV=16)
REQ-030 Reset, start=1, no buttons -> after 17 cycles step_pulse once, head (7,6), tail (4,6), score 0.
REQ-031 Direction right, pulse move_left then move_up -> left ignored, next step head (6,5) from (6,6).
REQ-032 Food forced at (7,6), head (6,6) moving right -> snake_len 5, score 1, new food not on any segment, FOOD exits to RUN.
REQ-033 Wrap off: head (11,6) moving right -> game_over=1, running=0, body unchanged; start=1 -> IDLE with reset body.
REQ-034 Wrap on: head (11,6) moving right -> head (0,6), running stays 1.
REQ-035 Length 5, steer up, left, down into own body -> OVER on the down step; reset pulsed mid-FOOD -> REQ-026 values.
